// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with a fixed 34-cycle
// turnaround. A 32-step shift-add multiplier and a 32-step restoring divider
// share one hi/lo working register pair; operands are reduced to magnitudes
// on accept and the sign is restored when the result is written.
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// divide/remainder ops still complete on schedule but flag illegal_op.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we,
  output logic            illegal_op
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;
  logic [5:0] cnt;

  logic accept, iterate, finish;

  // Latched operation context and working registers
  logic [2:0]      op_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] m_p0;
  logic            neg_q_p0;
  logic [XLEN-1:0] hi_p1, lo_p1;
  logic [XLEN-1:0] hi_n, lo_n;
`ifdef MULDIV_DIV_EN
  logic            neg_r_p0;
  logic            divz_p0;
  logic [XLEN-1:0] rs1_p0;
`endif

  // Operand sign interpretation and magnitudes at accept time
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   res_mul, res_div, res_fin;

  function automatic logic [XLEN-1:0] cond_neg32(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg64(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign a_sgn  = op[2] ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
  assign b_sgn  = op[2] ? ~op[0] : (op[1:0] == 2'b01);
  assign a_neg  = a_sgn & rs1_val[XLEN-1];
  assign b_neg  = b_sgn & rs2_val[XLEN-1];
  assign a_mag  = cond_neg32(rs1_val, a_neg);
  assign b_mag  = cond_neg32(rs2_val, b_neg);

  assign accept  = (state == IDLE) && start;
  assign iterate = (state == CALC) && (cnt != 6'(XLEN));
  assign finish  = (state == CALC) && (cnt == 6'(XLEN));

  // State register and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE)
        cnt <= '0;
      else if (iterate)
        cnt <= cnt + 6'd1;
    end
  end

  // Next-state logic: 32 iterations in CALC, then one DONE cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == 6'(XLEN)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic          ge;
    hi_n    = hi_p1;
    lo_n    = lo_p1;
    sum     = '0;
    shifted = '0;
    ge      = 1'b0;
    if (!op_p0[2]) begin
      sum  = {1'b0, hi_p1} + {1'b0, (lo_p1[0] ? m_p0 : '0)};
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_p1[XLEN-1:1]};
    end else begin
`ifdef MULDIV_DIV_EN
      shifted = {hi_p1, lo_p1[XLEN-1]};
      ge      = shifted >= {1'b0, m_p0};
      hi_n    = ge ? (shifted[XLEN-1:0] - m_p0) : shifted[XLEN-1:0];
      lo_n    = {lo_p1[XLEN-2:0], ge};
`endif
    end
  end

  // Operand capture on accept, working registers advance during CALC
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= op;
      rd_p0    <= rd_in;
      m_p0     <= op[2] ? b_mag : a_mag;
      neg_q_p0 <= a_neg ^ b_neg;
      hi_p1    <= '0;
      lo_p1    <= op[2] ? a_mag : b_mag;
`ifdef MULDIV_DIV_EN
      neg_r_p0 <= a_neg;
      divz_p0  <= (rs2_val == '0);
      rs1_p0   <= rs1_val;
`endif
    end else if (iterate) begin
      hi_p1 <= hi_n;
      lo_p1 <= lo_n;
    end
  end

  // Sign fix and result selection
  always_comb begin
    prod_fin = cond_neg64({hi_p1, lo_p1}, neg_q_p0);
    res_mul  = (op_p0[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    if (op_p0[1])
      res_div = divz_p0 ? rs1_p0 : cond_neg32(hi_p1, neg_r_p0);
    else
      res_div = divz_p0 ? '1 : cond_neg32(lo_p1, neg_q_p0);
`else
    res_div  = '0;
`endif
    res_fin  = op_p0[2] ? res_div : res_mul;
  end

  // Write-back registers load on entry to DONE and hold afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      rd_out <= '0;
    end else if (finish) begin
      result <= res_fin;
      rd_out <= rd_p0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
`ifdef MULDIV_DIV_EN
  assign illegal_op = 1'b0;
`else
  assign illegal_op = done & op_p0[2];
`endif
  assign we = done & (rd_out != 5'd0) & ~illegal_op;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with a behavioural model
// (arithmetic reference plus countdown timing) compared every cycle.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        busy, done, we, illegal_op;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out),
    .we(we), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
`ifdef MULDIV_DIV_EN
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  function automatic logic ref_ill(input logic [2:0] f);
`ifdef MULDIV_DIV_EN
    return 1'b0;
`else
    return f[2];
`endif
  endfunction

  // Timing model: countdown from 33 after an accepted start
  logic        m_act, m_ill, p_ill;
  int          m_cnt;
  logic [31:0] m_res, p_res;
  logic [4:0]  m_rd, p_rd;

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0; m_cnt <= 0; m_res <= '0; m_rd <= '0; m_ill <= 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1;
        m_cnt <= 33;
        p_res <= ref_res(op, rs1_val, rs2_val);
        p_rd  <= rd_in;
        p_ill <= ref_ill(op);
      end
    end else if (m_cnt == 0) begin
      m_act <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_res <= p_res; m_rd <= p_rd; m_ill <= p_ill;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_done;
      e_done = m_act && (m_cnt == 0);
      check("busy", {31'b0, busy}, {31'b0, m_act});
      check("done", {31'b0, done}, {31'b0, e_done});
      check("we", {31'b0, we}, {31'b0, e_done && (m_rd != 0) && !m_ill});
      check("illegal_op", {31'b0, illegal_op}, {31'b0, e_done && m_ill});
      check("result", result, m_res);
      check("rd_out", {27'b0, rd_out}, {27'b0, m_rd});
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; op = f; rs1_val = a; rs2_val = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) break;
      @(negedge clk);
      n = i;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout waiting for done actual=none required=done at %0t", $time);
    end
  endtask

  task automatic run_lit(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input logic exp_we, input logic exp_ill);
    int n;
    issue(f, a, b, rd);
    wait_done(n);
    if (done) begin
      check({name, "_latency"}, 32'(n), 32'd33);
      check({name, "_result"}, result, exp_res);
      check({name, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
      check({name, "_we"}, {31'b0, we}, {31'b0, exp_we});
      check({name, "_ill"}, {31'b0, illegal_op}, {31'b0, exp_ill});
    end
  endtask

  initial begin
    int  n;
    bit  saw_done;
    rst = 1'b1; start = 1'b1; op = 3'd0; rs1_val = 32'd1; rs2_val = 32'd1; rd_in = 5'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'b0, rd_out}, 32'd0);
    start = 1'b0; rst = 1'b0;

    run_lit("mul_neg", 3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b1, 1'b0);
    run_lit("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, 1'b1, 1'b0);
    run_lit("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, 1'b1, 1'b0);
    run_lit("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_lit("mulh_min", 3'd1, 32'h80000000, 32'h80000000, 5'd9, 32'h40000000, 1'b1, 1'b0);
    run_lit("mul_rd0", 3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 1'b0, 1'b0);
`ifdef MULDIV_DIV_EN
    run_lit("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1'b1, 1'b0);
    run_lit("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h00000000, 1'b1, 1'b0);
    run_lit("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd12, 32'hFFFFFFFD, 1'b1, 1'b0);
    run_lit("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd13, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_lit("divu_z", 3'd5, 32'd100, 32'd0, 5'd14, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_lit("remu_z", 3'd7, 32'd100, 32'd0, 5'd15, 32'd100, 1'b1, 1'b0);
`else
    run_lit("div_off", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h0, 1'b0, 1'b1);
    run_lit("rem_off", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd13, 32'h0, 1'b0, 1'b1);
    run_lit("divu_off", 3'd5, 32'd100, 32'd0, 5'd14, 32'h0, 1'b0, 1'b1);
    run_lit("remu_off", 3'd7, 32'd100, 32'd0, 5'd15, 32'h0, 1'b0, 1'b1);
`endif

    // Second start during CALC is ignored
    issue(3'd0, 32'd6, 32'd7, 5'd9);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd3; rs1_val = 32'd5; rs2_val = 32'd5; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ignored_start_result", result, 32'd42);
    check("ignored_start_rd", {27'b0, rd_out}, 32'd9);

    // Reset mid-operation aborts it
    issue(3'd0, 32'd11, 32'd13, 5'd4);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);
    run_lit("after_abort", 3'd0, 32'd11, 32'd13, 5'd4, 32'd143, 1'b1, 1'b0);

    // Model-checked mixed operands
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), $urandom, (i == 5) ? 32'd0 : $urandom, 5'($urandom_range(0, 31)));
      wait_done(n);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
